wb_unified_mem: RTL

WB_UNIFIED_MEM -- requirements
Module: wb_unified_mem

---
 rtl/wb_unified_mem.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_unified_mem.sv
// Unified instruction/data Wishbone memory with per-port wait states and a tohost mailbox.
// Each port runs its own IDLE/WAIT/RESP sequencer; reads and writes resolve on entry to RESP.
module wb_unified_mem #(
    parameter int          DEPTH      = 8192,
    parameter int          IWAIT      = 0,
    parameter int          DWAIT      = 0,
    parameter int          TOHOST_IDX = 1024,
    parameter logic [31:0] FILL       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iwb_adr_i,
    input  logic        iwb_cyc_i,
    input  logic        iwb_stb_i,
    output logic [31:0] iwb_dat_o,
    output logic        iwb_ack_o,
    output logic        iwb_err_o,
    input  logic [31:0] dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    input  logic        dwb_we_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_stb_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        dwb_err_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [30:0] code_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] IWAIT_C = 4'(IWAIT);
    localparam logic [3:0] DWAIT_C = 4'(DWAIT);
    localparam logic          TOHOST_OK = (TOHOST_IDX < DEPTH);
    localparam logic [AW-1:0] TOHOST_W  = AW'(TOHOST_IDX);

    // Power-up content is FILL; a bench or loader may overwrite words hierarchically.
    logic [31:0] mem_q [DEPTH] = '{default: FILL};

    logic [1:0]    istate_q, istate_d;
    logic [3:0]    icnt_q, icnt_d;
    logic [AW-1:0] iidx_q, iidx_d;
    logic          ioor_q, ioor_d;
    logic [31:0]   irdata_q;
    logic          i_req, i_oor_in, i_enter;

    logic [1:0]    dstate_q, dstate_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic [AW-1:0] didx_q, didx_d;
    logic          door_q, door_d;
    logic          dwe_q, dwe_d;
    logic [3:0]    dsel_q, dsel_d;
    logic [31:0]   dwdat_q, dwdat_d;
    logic [31:0]   drdata_q;
    logic          d_req, d_oor_in, d_enter, d_commit, d_tohost;

    logic          done_q, pass_q;
    logic [30:0]   code_q;

    logic unused_adr_lsb;
    assign unused_adr_lsb = ^{iwb_adr_i[1:0], dwb_adr_i[1:0]};

    assign i_req    = iwb_cyc_i & iwb_stb_i;
    assign d_req    = dwb_cyc_i & dwb_stb_i;
    assign i_oor_in = |iwb_adr_i[31:AW+2];
    assign d_oor_in = |dwb_adr_i[31:AW+2];

    always_comb begin
        istate_d = istate_q;
        icnt_d   = icnt_q;
        iidx_d   = iidx_q;
        ioor_d   = ioor_q;
        i_enter  = 1'b0;
        case (istate_q)
            S_IDLE: if (i_req) begin
                iidx_d = iwb_adr_i[AW+1:2];
                ioor_d = i_oor_in;
                if (IWAIT_C == 4'd0) begin
                    istate_d = S_RESP;
                    i_enter  = 1'b1;
                end else begin
                    istate_d = S_WAIT;
                    icnt_d   = IWAIT_C;
                end
            end
            S_WAIT: if (!iwb_cyc_i) begin
                istate_d = S_IDLE;
                icnt_d   = 4'd0;
            end else if (icnt_q == 4'd1) begin
                istate_d = S_RESP;
                icnt_d   = 4'd0;
                i_enter  = 1'b1;
            end else begin
                icnt_d = icnt_q - 4'd1;
            end
            S_RESP:  istate_d = S_IDLE;
            default: istate_d = S_IDLE;
        endcase
    end

    always_comb begin
        dstate_d = dstate_q;
        dcnt_d   = dcnt_q;
        didx_d   = didx_q;
        door_d   = door_q;
        dwe_d    = dwe_q;
        dsel_d   = dsel_q;
        dwdat_d  = dwdat_q;
        d_enter  = 1'b0;
        case (dstate_q)
            S_IDLE: if (d_req) begin
                didx_d  = dwb_adr_i[AW+1:2];
                door_d  = d_oor_in;
                dwe_d   = dwb_we_i;
                dsel_d  = dwb_sel_i;
                dwdat_d = dwb_dat_i;
                if (DWAIT_C == 4'd0) begin
                    dstate_d = S_RESP;
                    d_enter  = 1'b1;
                end else begin
                    dstate_d = S_WAIT;
                    dcnt_d   = DWAIT_C;
                end
            end
            S_WAIT: if (!dwb_cyc_i) begin
                dstate_d = S_IDLE;
                dcnt_d   = 4'd0;
            end else if (dcnt_q == 4'd1) begin
                dstate_d = S_RESP;
                dcnt_d   = 4'd0;
                d_enter  = 1'b1;
            end else begin
                dcnt_d = dcnt_q - 4'd1;
            end
            S_RESP:  dstate_d = S_IDLE;
            default: dstate_d = S_IDLE;
        endcase
    end

    // Gate with rst_n so a zero-wait request held during reset cannot write.
    assign d_commit = d_enter & dwe_d & ~door_d & rst_n;
    assign d_tohost = d_commit & TOHOST_OK & (didx_d == TOHOST_W) & (dwdat_d != 32'd0) & ~done_q;

    always_ff @(posedge clk) begin
        if (d_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (dsel_d[k]) mem_q[didx_d][8*k +: 8] <= dwdat_d[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            istate_q <= S_IDLE;
            icnt_q   <= 4'd0;
            iidx_q   <= '0;
            ioor_q   <= 1'b0;
            irdata_q <= 32'd0;
            dstate_q <= S_IDLE;
            dcnt_q   <= 4'd0;
            didx_q   <= '0;
            door_q   <= 1'b0;
            dwe_q    <= 1'b0;
            dsel_q   <= 4'd0;
            dwdat_q  <= 32'd0;
            drdata_q <= 32'd0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            code_q   <= 31'd0;
        end else begin
            istate_q <= istate_d;
            icnt_q   <= icnt_d;
            iidx_q   <= iidx_d;
            ioor_q   <= ioor_d;
            dstate_q <= dstate_d;
            dcnt_q   <= dcnt_d;
            didx_q   <= didx_d;
            door_q   <= door_d;
            dwe_q    <= dwe_d;
            dsel_q   <= dsel_d;
            dwdat_q  <= dwdat_d;
            // Nonblocking reads see the pre-write word when both ports land on the same edge.
            if (i_enter) irdata_q <= mem_q[iidx_d];
            if (d_enter) drdata_q <= mem_q[didx_d];
            if (d_tohost) begin
                done_q <= 1'b1;
                pass_q <= (dwdat_d == 32'd1);
                code_q <= dwdat_d[31:1];
            end
        end
    end

    assign iwb_ack_o = (istate_q == S_RESP) & ~ioor_q;
    assign iwb_err_o = (istate_q == S_RESP) & ioor_q;
    assign iwb_dat_o = iwb_ack_o ? irdata_q : 32'd0;
    assign dwb_ack_o = (dstate_q == S_RESP) & ~door_q;
    assign dwb_err_o = (dstate_q == S_RESP) & door_q;
    assign dwb_dat_o = dwb_ack_o ? drdata_q : 32'd0;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign code_o    = code_q;
endmodule
